// File: rtl/park_pipe.sv
// park_pipe: three-stage Park / inverse-Park rotator with valid/ready flow.
//   S1 registers the four products, S2 the rotated sums, S3 the rounded and
//   narrowed result (output register). All stages advance together on adv.
// Build option: define PARK_SAT_EN to clamp on narrowing and drive sat_flag;
//   otherwise narrowing wraps and sat_flag is tied low.

// Narrow a rounded result to the output width (clamp or wrap).
module park_narrow #(
   parameter int IW = 23,
   parameter int OW = 18
) (
   input  logic [IW-1:0] r,
   output logic [OW-1:0] y,
   output logic          clamped
);
   logic [IW-OW:0] hi;
   logic           fits;

   // r fits when every bit above the output sign bit matches it
   always_comb begin
      hi   = r[IW-1:OW-1];
      fits = (&hi) || !(|hi);
`ifdef PARK_SAT_EN
      y       = r[OW-1:0];
      clamped = 1'b0;
      if (!fits) begin
         y       = r[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
         clamped = 1'b1;
      end
`else
      y       = r[OW-1:0];
      clamped = 1'b0;
`endif
   end

`ifndef PARK_SAT_EN
   logic unused_fits;
   assign unused_fits = fits;
`endif
endmodule

module park_pipe #(
   parameter int D_WIDTH = 18,
   parameter int Q_BITS  = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      inv,
   input  logic signed [D_WIDTH-1:0] x_a,
   input  logic signed [D_WIDTH-1:0] x_b,
   input  logic signed [D_WIDTH-1:0] sin,
   input  logic signed [D_WIDTH-1:0] cos,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [D_WIDTH-1:0] out_a,
   output logic signed [D_WIDTH-1:0] out_b,
   output logic                      sat_flag
);
   localparam int STAGES = 3;
   localparam int PW     = 2 * D_WIDTH;     // product width
   localparam int SW     = PW + 1;          // sum width
   localparam int RW     = SW + 1 - Q_BITS; // rounded width before narrowing
   localparam logic signed [SW:0] HALF = (SW + 1)'(1) << (Q_BITS - 1);

   logic                     adv;
   logic [STAGES:1]          vld_pipe_q, vld_pipe_d;
   logic signed [PW-1:0]     ca_q, sb_q, cb_q, sa_q, ca_d, sb_d, cb_d, sa_d;
   logic                     inv1_q, inv1_d;
   logic signed [SW-1:0]     ca_x, sb_x, cb_x, sa_x;
   logic [1:0][SW-1:0]       sum_q, sum_d;
   logic [1:0][RW-1:0]       rnd;
   logic [1:0][D_WIDTH-1:0]  nar;
   logic [1:0]               clamp;
   logic signed [D_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic                     sat_q, sat_d;

   assign adv       = !vld_pipe_q[STAGES] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe_q[STAGES];
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign sat_flag  = sat_q;

   // valid shift register: shift in in_valid on advance, hold otherwise
   always_comb begin
      vld_pipe_d = vld_pipe_q;
      if (adv) vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
   end

   // S1: four products and the mode bit
   always_comb begin
      ca_d   = ca_q;
      sb_d   = sb_q;
      cb_d   = cb_q;
      sa_d   = sa_q;
      inv1_d = inv1_q;
      if (adv) begin
         ca_d   = cos * x_a;
         sb_d   = sin * x_b;
         cb_d   = cos * x_b;
         sa_d   = sin * x_a;
         inv1_d = inv;
      end
   end

   // S2: rotate; lane 0 is out_a, lane 1 is out_b
   always_comb begin
      ca_x  = {ca_q[PW-1], ca_q};
      sb_x  = {sb_q[PW-1], sb_q};
      cb_x  = {cb_q[PW-1], cb_q};
      sa_x  = {sa_q[PW-1], sa_q};
      sum_d = sum_q;
      if (adv) begin
         sum_d[0] = inv1_q ? (ca_x - sb_x) : (ca_x + sb_x);
         sum_d[1] = inv1_q ? (sa_x + cb_x) : (cb_x - sa_x);
      end
   end

   // S3 lanes: round half up, take the high bits (arithmetic shift), narrow
   for (genvar l = 0; l < 2; l++) begin : g_lane
      logic signed [SW:0] biased;
      assign biased = $signed({sum_q[l][SW-1], sum_q[l]}) + HALF;
      assign rnd[l] = biased[SW:Q_BITS];
      park_narrow #(.IW(RW), .OW(D_WIDTH)) u_narrow (
         .r       (rnd[l]),
         .y       (nar[l]),
         .clamped (clamp[l])
      );
   end

   // S3 output register next state, held while stalled
   always_comb begin
      out_a_d = out_a_q;
      out_b_d = out_b_q;
      sat_d   = sat_q;
      if (adv) begin
         out_a_d = nar[0];
         out_b_d = nar[1];
         sat_d   = |clamp;
      end
   end

   // datapath stages carry no reset; their valid bits cover them
   always_ff @(posedge clk) begin
      ca_q   <= ca_d;
      sb_q   <= sb_d;
      cb_q   <= cb_d;
      sa_q   <= sa_d;
      inv1_q <= inv1_d;
      sum_q  <= sum_d;
   end

   // valid bits and output register, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
         out_a_q    <= '0;
         out_b_q    <= '0;
         sat_q      <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         out_a_q    <= out_a_d;
         out_b_q    <= out_b_d;
         sat_q      <= sat_d;
      end
   end
endmodule
